// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer game.
package reaction_pkg;

    typedef enum logic [1:0] {
        START  = 2'd0,
        READY  = 2'd1,
        PLAY   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned DELAY_W = 8;
    localparam int unsigned LFSR_W  = 8;

    localparam logic [DIGIT_W-1:0] BLANK     = 4'hF;
    localparam logic [LFSR_W-1:0]  LFSR_SEED = 8'hA5;

    // Fibonacci step for x^8+x^6+x^5+x^4+1.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Player inputs and display/status outputs of the reaction timer.
interface reaction_timer_if;
    import reaction_pkg::*;

    logic                btn;
    logic                tick;
    logic [DIGIT_W-1:0]  tens;
    logic [DIGIT_W-1:0]  ones;
    logic                go_led;
    logic                early;
    state_t              state;

    modport master (output btn, tick, input tens, ones, go_led, early, state);
    modport slave  (input btn, tick, output tens, ones, go_led, early, state);

endinterface

// File: rtl/btn_sync.sv
// Button synchronizer plus rising-edge detector: one clk pulse per press.
module btn_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic press_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q[0] <= btn_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Decoded from flops only, so the pulse is clean for the FSM.
    assign press_out = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer game: random READY wait, then counts tenths until the player presses.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int unsigned MIN_DELAY   = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    reaction_timer_if.slave   bus
);

    logic                press;
    state_t              state_q;
    logic [DIGIT_W-1:0]  tens_q;
    logic [DIGIT_W-1:0]  ones_q;
    logic                go_q;
    logic                early_q;
    logic [DELAY_W-1:0]  delay_q;
    logic [LFSR_W-1:0]   lfsr_q;

    btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (bus.btn),
        .press_out (press)
    );

    // Game FSM with the LFSR and BCD counter folded into the same register block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= START;
            tens_q  <= '0;
            ones_q  <= '0;
            go_q    <= 1'b0;
            early_q <= 1'b0;
            delay_q <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            case (state_q)
                START: begin
                    if (press) begin
                        delay_q <= DELAY_W'(MIN_DELAY) + DELAY_W'(lfsr_q[4:0]);
                        tens_q  <= BLANK;
                        ones_q  <= BLANK;
                        state_q <= READY;
                    end
                end
                READY: begin
                    // A press beats a terminal tick arriving in the same clk.
                    if (press) begin
                        early_q <= 1'b1;
                        state_q <= FINISH;
                    end else if (bus.tick) begin
                        if (delay_q <= DELAY_W'(1)) begin
                            delay_q <= '0;
                            tens_q  <= '0;
                            ones_q  <= '0;
                            go_q    <= 1'b1;
                            state_q <= PLAY;
                        end else begin
                            delay_q <= delay_q - DELAY_W'(1);
                        end
                    end
                end
                PLAY: begin
                    if (press) begin
                        go_q    <= 1'b0;
                        state_q <= FINISH;
                    end else if (bus.tick) begin
                        if (tens_q == DIGIT_W'(9) && ones_q == DIGIT_W'(9)) begin
                            go_q    <= 1'b0;
                            state_q <= FINISH;
                        end else if (ones_q == DIGIT_W'(9)) begin
                            ones_q <= '0;
                            tens_q <= tens_q + DIGIT_W'(1);
                        end else begin
                            ones_q <= ones_q + DIGIT_W'(1);
                        end
                    end
                end
                FINISH: begin
                    if (press) begin
                        early_q <= 1'b0;
                        tens_q  <= '0;
                        ones_q  <= '0;
                        state_q <= START;
                    end
                end
                default: state_q <= START;
            endcase
        end
    end

    assign bus.state  = state_q;
    assign bus.tens   = tens_q;
    assign bus.ones   = ones_q;
    assign bus.go_led = go_q;
    assign bus.early  = early_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: a tenths-level game model predicts every output change.
`timescale 1ns/1ps
module tb_reaction_timer;
    import reaction_pkg::*;

    localparam int unsigned MIN_DELAY   = 10;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          S           = int'(SYNC_STAGES);
    localparam int          TICK_P      = 20;

    typedef struct {
        int          cyc;
        logic [11:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    reaction_timer_if bus();

    reaction_timer #(.MIN_DELAY(MIN_DELAY), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          press_due = -1;
    logic        tick_en = 1'b0;
    logic        go_seen = 1'b0;
    exp_t        sb[$];
    logic [11:0] mon_prev = '0;

    state_t      m_st;
    int          m_cnt, m_delay, m_ready_ticks;
    logic        m_early;
    logic [7:0]  m_lfsr;
    logic [11:0] m_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] m_vec();
        logic [3:0] t, o;
        if (m_st == READY || (m_st == FINISH && m_early)) begin
            t = BLANK; o = BLANK;
        end else begin
            t = 4'(m_cnt / 10); o = 4'(m_cnt % 10);
        end
        return {m_st, t, o, (m_st == PLAY), m_early};
    endfunction

    task automatic model_reset();
        m_st = START; m_cnt = 0; m_delay = 0; m_early = 1'b0; m_ready_ticks = 0;
        m_lfsr = 8'hA5; press_due = -1; m_prev = '0; mon_prev = '0;
        sb.delete();
    endtask

    task automatic model_step();
        logic [7:0] old;
        logic       press;
        logic [11:0] v;
        exp_t       e;
        cyc++;
        if (reset) return;
        old    = m_lfsr;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        press  = (cyc == press_due);
        case (m_st)
            START: if (press) begin
                m_delay = int'(MIN_DELAY) + int'(old[4:0]); m_ready_ticks = 0; m_st = READY;
            end
            READY: if (press) begin
                m_st = FINISH; m_early = 1'b1;
            end else if (bus.tick) begin
                m_ready_ticks++;
                if (m_delay == 1) begin m_st = PLAY; m_cnt = 0; end
                else m_delay--;
            end
            PLAY: if (press) m_st = FINISH;
                  else if (bus.tick) begin
                      if (m_cnt == 99) m_st = FINISH; else m_cnt++;
                  end
            FINISH: if (press) begin m_st = START; m_early = 1'b0; m_cnt = 0; end
            default: ;
        endcase
        v = m_vec();
        if (v != m_prev) begin
            e.cyc = cyc; e.v = v;
            sb.push_back(e);
            m_prev = v;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin
        bus.tick = 1'b0;
        forever begin
            @(negedge clk);
            bus.tick = tick_en && ((cyc % TICK_P) == TICK_P - 1);
        end
    end

    // Monitor: every change of the DUT outputs must match the next predicted change, on the same cycle.
    initial begin
        logic [11:0] obs;
        logic        ok;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                obs = {bus.state, bus.tens, bus.ones, bus.go_led, bus.early};
                if (bus.go_led) go_seen = 1'b1;
                if (obs != mon_prev) begin
                    ok = (bus.tens <= 4'd9 || bus.tens == BLANK) && (bus.ones <= 4'd9 || bus.ones == BLANK);
                    chk("digit_range", 32'(ok), 32'd1);
                    if (sb.size() == 0) begin
                        chk("unexpected_change", 32'(obs), 32'(mon_prev));
                    end else begin
                        e = sb.pop_front();
                        chk("change_cycle", e.cyc == cyc ? 32'(cyc) : 32'(cyc), 32'(e.cyc));
                        chk("state",  32'(obs[11:10]), 32'(e.v[11:10]));
                        chk("digits", 32'(obs[9:2]),   32'(e.v[9:2]));
                        chk("go_led", 32'(obs[1]),     32'(e.v[1]));
                        chk("early",  32'(obs[0]),     32'(e.v[0]));
                    end
                    mon_prev = obs;
                end
            end
        end
    end

    task automatic do_press();
        bus.btn = 1'b1;
        press_due = cyc + S + 1;
        repeat (3) @(negedge clk);
        bus.btn = 1'b0;
        repeat (S + 2) @(negedge clk);
    endtask

    task automatic press_on_next_tick();
        int e;
        e = (cyc / TICK_P + 1) * TICK_P;
        if (e - S - 1 < cyc) e += TICK_P;
        while (cyc < e - S - 1) @(negedge clk);
        do_press();
    endtask

    task automatic wait_state(input state_t s, input int budget, input string tag);
        int n = 0;
        while (m_st != s && n < budget) begin @(negedge clk); n++; end
        if (m_st != s) chk({tag, "_timeout"}, 32'(m_st), 32'(s));
    endtask

    task automatic wait_play_cnt(input int c, input int budget, input string tag);
        int n = 0;
        while (!(m_st == PLAY && m_cnt == c) && n < budget) begin @(negedge clk); n++; end
        if (!(m_st == PLAY && m_cnt == c)) chk({tag, "_timeout"}, 32'(m_cnt), 32'(c));
    endtask

    task automatic wait_ready(input int ticks, input int delay, input int budget, input string tag);
        int n = 0;
        while (!(m_st == READY && (m_ready_ticks == ticks || m_delay == delay)) && n < budget) begin
            @(negedge clk); n++;
        end
        if (m_st != READY) chk({tag, "_timeout"}, 32'(m_st), 32'(READY));
    endtask

    task automatic reset_pulse(input logic hold_btn);
        #2;
        reset = 1'b1;
        bus.btn = hold_btn;
        #1;
        chk("rst_state", 32'(bus.state), 32'(START));
        chk("rst_digits", 32'({bus.tens, bus.ones}), 32'h00);
        chk("rst_go", 32'(bus.go_led), 32'd0);
        chk("rst_early", 32'(bus.early), 32'd0);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'hA5);
        chk("rst_delay", 32'(dut.delay_q), 32'd0);
        chk("rst_sync", 32'(dut.u_sync.sync_q), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        if (hold_btn) press_due = cyc + S + 1;
    endtask

    initial begin
        reset = 1'b1;
        bus.btn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_pulse(1'b0);
        tick_en = 1'b1;

        // Full round to timeout.
        while (cyc < 9) @(negedge clk);
        do_press();
        wait_state(READY, 20, "t1_ready");
        chk("t1_delay_load", 32'(dut.delay_q), 32'(m_delay));
        wait_state(FINISH, 3000, "t1_finish");
        chk("t1_timeout_digits", 32'({bus.tens, bus.ones}), 32'h99);
        chk("t1_timeout_early", 32'(bus.early), 32'd0);
        do_press();
        wait_state(START, 20, "t1_start");

        // Early press after three READY ticks.
        do_press();
        wait_state(READY, 20, "t2_ready");
        go_seen = 1'b0;
        wait_ready(3, -1, 200, "t2_ticks");
        do_press();
        wait_state(FINISH, 20, "t2_finish");
        chk("t2_early", 32'(bus.early), 32'd1);
        chk("t2_blank", 32'({bus.tens, bus.ones}), 32'hFF);
        chk("t2_go_never", 32'(go_seen), 32'd0);
        do_press();
        wait_state(START, 20, "t2_start");
        chk("t2_start_digits", 32'({bus.tens, bus.ones}), 32'h00);

        // Stop at 27, then ticks must not move the frozen display.
        do_press();
        wait_play_cnt(27, 1600, "t3_cnt");
        do_press();
        wait_state(FINISH, 20, "t3_finish");
        chk("t3_frozen", 32'({bus.tens, bus.ones}), 32'h27);
        repeat (100) @(negedge clk);
        chk("t3_still_frozen", 32'({bus.tens, bus.ones}), 32'h27);
        do_press();
        wait_state(START, 20, "t3_start");

        // Press coincident with a PLAY tick at 05.
        do_press();
        wait_play_cnt(5, 1000, "t4_cnt");
        press_on_next_tick();
        wait_state(FINISH, 20, "t4_finish");
        chk("t4_frozen", 32'({bus.tens, bus.ones}), 32'h05);
        do_press();
        wait_state(START, 20, "t4_start");

        // Press coincident with the terminal READY tick.
        do_press();
        wait_ready(-1, 1, 900, "t5_delay1");
        press_on_next_tick();
        wait_state(FINISH, 20, "t5_finish");
        chk("t5_early", 32'(bus.early), 32'd1);
        do_press();
        wait_state(START, 20, "t5_start");

        // Button held for 500 clks gives a single press.
        tick_en = 1'b0;
        bus.btn = 1'b1;
        press_due = cyc + S + 1;
        repeat (500) @(negedge clk);
        bus.btn = 1'b0;
        repeat (S + 2) @(negedge clk);
        chk("t6_hold_state", 32'(bus.state), 32'(READY));
        chk("t6_hold_early", 32'(bus.early), 32'd0);
        tick_en = 1'b1;
        do_press();
        wait_state(FINISH, 20, "t6_finish");
        do_press();
        wait_state(START, 20, "t6_start");

        // Button held across reset release, then async reset mid-PLAY at 42.
        reset_pulse(1'b1);
        repeat (10) @(negedge clk);
        bus.btn = 1'b0;
        chk("t7_held_press", 32'(bus.state), 32'(READY));
        wait_play_cnt(42, 2000, "t7_cnt");
        reset_pulse(1'b0);

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001: Parameter MIN_DELAY, default 10, minimum READY wait in tenths ticks (1.0 s).
REQ-002: Parameter SYNC_STAGES, default 2, button synchronizer depth.
REQ-003: clk  input  1  single design clock; all flops on its rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: btn  input  1  raw player button, asynchronous to clk, active-high.
REQ-006: tick  input  1  one-clk-wide strobe, one per 0.1 s, synchronous to clk.
REQ-007: tens  output  4  BCD tens digit to the seven-segment driver; 4'hF = blank.
REQ-008: ones  output  4  BCD ones digit to the seven-segment driver; 4'hF = blank.
REQ-009: go_led  output  1  high only in PLAY (player cue).
REQ-010: early  output  1  high in FINISH when the player pressed during READY.
REQ-011: state  output  2  current FSM state: START=0, READY=1, PLAY=2, FINISH=3.

Function
REQ-012: btn SHALL pass through SYNC_STAGES flops; a press is a synchronized 0->1 edge, giving exactly one clk-wide internal pulse.
REQ-013: Press latency from btn rise to FSM action SHALL be SYNC_STAGES+1 clks.
REQ-014: An 8-bit Fibonacci LFSR SHALL use polynomial x^8+x^6+x^5+x^4+1, reset to 8'hA5, and advance every clk in every state.
REQ-015: START: tens=ones=0, go_led=0; on a press, load delay = MIN_DELAY + lfsr[4:0] (range MIN_DELAY..MIN_DELAY+31) and go to READY.
REQ-016: READY: tens=ones=4'hF; on each tick decrement delay; when a tick occurs with delay==1, clear the BCD count and go to PLAY.
REQ-017: READY with a press: go to FINISH, set early=1, digits stay 4'hF.
REQ-018: READY with a press and the terminal tick in the same clk: the press SHALL win (early=1, FINISH).
REQ-019: PLAY: go_led=1; each tick increments the BCD count; ones wraps 9->0 with a tens carry.
REQ-020: PLAY at 99: the next tick SHALL hold 99 and go to FINISH (timeout, early=0).
REQ-021: PLAY with a press: go to FINISH and freeze the count; a tick in the same clk SHALL NOT increment.
REQ-022: FINISH: hold the digits and early; go_led=0; a press returns to START and clears early.
REQ-023: Digit outputs SHALL be registered, never exceed 9 except the 4'hF blank, and change only on state transitions or PLAY ticks.
REQ-024: A held button SHALL produce no further presses until it is released and pressed again.

Reset
REQ-025: Reset asserted at any time, including mid-READY or mid-PLAY, SHALL immediately force: state=START, tens=ones=0, go_led=0, early=0, delay=0, lfsr=8'hA5, synchronizer flops=0.
REQ-026: After reset deasserts, a btn already held high SHALL register as one press once it is synchronized.

Structure
REQ-027: Shared package reaction_pkg SHALL hold the state_t enum (START, READY, PLAY, FINISH), BLANK=4'hF, and the LFSR reset seed.
REQ-028: The synchronizer and edge detector SHALL be one sub-module btn_sync (clk, reset, btn_in, press_out); the FSM, LFSR and BCD counter stay in reaction_timer.

Verification
REQ-029: Reset, press at cycle 10, tick every 20 clks, no further press -> READY for MIN_DELAY+lfsr[4:0] ticks, then PLAY with go_led=1, 00 counting up, timeout to FINISH at 99, early=0.
REQ-030: Press during READY after 3 ticks -> FINISH, early=1, tens=ones=4'hF, go_led never 1; next press -> START showing 00.
REQ-031: In PLAY, press after 27 ticks -> FINISH freezes tens=2, ones=7; ticks for 100 more clks leave the digits unchanged.
REQ-032: Press pulse aligned with a PLAY tick at count 05 -> frozen at 05; press aligned with the terminal READY tick -> early=1.
REQ-033: btn held high for 500 clks across START->READY -> only one press; glitch-free single state step.
REQ-034: Reset pulse mid-PLAY at count 42 -> all outputs return to their reset values in the same clk (async), and LFSR=8'hA5.
